// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main sequencing FSM of the 16-bit multicycle RISC-V core.
// Drives every datapath enable, the ALUOp class, and flags illegal opcodes / memory timeouts.
`default_nettype none

module multicycle_main_control #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_err,
  output logic       halted
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BR   = 4'b0100;
  localparam logic [3:0] OP_JAL  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic          illegal_q, mem_err_q;
  logic          set_illegal, timeout, mem_state, wait_last;

  // Last allowed wait cycle: one more miss would make the counter reach MEM_WAIT_MAX.
  assign wait_last = !mem_ready && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (set_illegal) illegal_q <= 1'b1;
      if (timeout)     mem_err_q <= 1'b1;
      if (nxt != cur || mem_ready || !mem_state) wait_cnt <= '0;
      else                                       wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    set_illegal = 1'b0;
    timeout     = 1'b0;
    mem_state   = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;

    case (cur)
      S_FETCH: begin
        mem_state = 1'b1;
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) nxt = S_DECODE;
        else if (wait_last) begin
          nxt     = S_HALT;
          timeout = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R:          nxt = S_EXEC_R;
          OP_ADDI:       nxt = S_EXEC_I;
          OP_LW, OP_SW:  nxt = S_MEMADR;
          OP_BR:         nxt = S_BRANCH;
          OP_JAL:        nxt = S_JAL;
          OP_HALT:       nxt = S_HALT;
          default: begin
            nxt         = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)      nxt = S_MEMREAD;
        else if (opcode == OP_SW) nxt = S_MEMWRITE;
        else                      nxt = S_FETCH;
      end
      S_MEMREAD: begin
        mem_state = 1'b1;
        MemRead   = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
        else if (wait_last) begin
          nxt     = S_HALT;
          timeout = 1'b1;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        nxt      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_state = 1'b1;
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) nxt = S_FETCH;
        else if (wait_last) begin
          nxt     = S_HALT;
          timeout = 1'b1;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
        nxt     = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        nxt         = S_FETCH;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
        PCWrite  = 1'b1;
        PCSource = 2'b01;
        nxt      = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_FETCH;
    endcase

    // Reset forces every strobe low so nothing writes during the reset cycle.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 2'b00;
      RegWrite    = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      halted      = 1'b0;
    end
  end

  assign state      = rst ? 4'd0 : cur;
  assign illegal_op = illegal_q & ~rst;
  assign mem_err    = mem_err_q & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: scripted state sequences,
// expected output vectors queued per cycle and compared against the DUT.
`default_nettype none

module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       illegal_op, mem_err, halted;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb[$];

  multicycle_main_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .mem_err(mem_err), .halted(halted)
  );

  always #5 clk = ~clk;

  // Field order: state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  // MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_err, halted
  function automatic logic [23:0] observed();
    return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            illegal_op, mem_err, halted};
  endfunction

  function automatic logic [23:0] expected(input bit r, input logic [3:0] st,
                                           input bit mr, input bit ill, input bit me);
    logic pcw, pcc, iord, mrd, mwr, irw, rw, hlt;
    logic [1:0] m2r, sa, sb_, aop, pcs;
    {pcw, pcc, iord, mrd, mwr, irw, rw, hlt} = '0;
    {m2r, sa, sb_, aop, pcs} = '0;
    if (r) return 24'd0;
    case (st)
      4'd0:  begin mrd = 1; sb_ = 2'b01; irw = mr; pcw = mr; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 2'b01; sb_ = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin sa = 2'b01; aop = 2'b10; end
      4'd7:  begin sa = 2'b01; sb_ = 2'b10; aop = 2'b11; end
      4'd8:  rw = 1;
      4'd9:  begin sa = 2'b01; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd10: begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 2'b01; end
      4'd11: hlt = 1;
      default: ;
    endcase
    return {st, pcw, pcc, iord, mrd, mwr, irw, m2r, rw, sa, sb_, aop, pcs, ill, me, hlt};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected vector, then compare.
  task automatic cyc(input bit r, input logic [3:0] op, input bit mr,
                     input logic [3:0] st, input bit ill, input bit me, input string tag);
    @(negedge clk);
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    sb.push_back(expected(r, st, mr, ill, me));
    #2;
    check(tag, observed(), sb.pop_front());
  endtask

  initial begin
    // Test 1: R-type, zero wait
    cyc(1, 4'b0000, 1, 0, 0, 0, "reset");
    cyc(0, 4'b0000, 1, 0, 0, 0, "r_fetch");
    cyc(0, 4'b0000, 1, 1, 0, 0, "r_decode");
    cyc(0, 4'b0000, 1, 6, 0, 0, "r_exec");
    cyc(0, 4'b0000, 1, 8, 0, 0, "r_aluwb");
    // Test 2: LW with 3 wait cycles in MEMREAD (mem_ready ignored in DECODE)
    cyc(0, 4'b0010, 1, 0, 0, 0, "lw_fetch");
    cyc(0, 4'b0010, 0, 1, 0, 0, "lw_decode");
    cyc(0, 4'b0010, 1, 2, 0, 0, "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0010, 0, 3, 0, 0, "lw_memread_wait");
    cyc(0, 4'b0010, 1, 3, 0, 0, "lw_memread_done");
    cyc(0, 4'b0010, 1, 4, 0, 0, "lw_memwb");
    // Test 3: SW zero wait then BR
    cyc(0, 4'b0011, 1, 0, 0, 0, "sw_fetch");
    cyc(0, 4'b0011, 1, 1, 0, 0, "sw_decode");
    cyc(0, 4'b0011, 1, 2, 0, 0, "sw_memadr");
    cyc(0, 4'b0011, 1, 5, 0, 0, "sw_memwrite");
    cyc(0, 4'b0100, 1, 0, 0, 0, "br_fetch");
    cyc(0, 4'b0100, 1, 1, 0, 0, "br_decode");
    cyc(0, 4'b0100, 1, 9, 0, 0, "br_branch");
    // Test 4: illegal opcode, sticky through later instructions
    cyc(0, 4'b1010, 1, 0, 0, 0, "ill_fetch");
    cyc(0, 4'b1010, 1, 1, 0, 0, "ill_decode");
    cyc(0, 4'b0001, 1, 0, 1, 0, "addi_fetch_ill");
    cyc(0, 4'b0001, 1, 1, 1, 0, "addi_decode");
    cyc(0, 4'b0001, 1, 7, 1, 0, "addi_exec");
    cyc(0, 4'b0001, 1, 8, 1, 0, "addi_aluwb");
    cyc(0, 4'b1111, 1, 0, 1, 0, "halt_fetch");
    cyc(0, 4'b1111, 1, 1, 1, 0, "halt_decode");
    for (int i = 0; i < 3; i++) cyc(0, 4'b1111, 1, 11, 1, 0, "halt_stay");
    cyc(1, 4'b1111, 1, 0, 0, 0, "reset_from_halt");
    // Test 5: fetch timeout
    for (int i = 0; i < 15; i++) cyc(0, 4'b0000, 0, 0, 0, 0, "to_fetch_wait");
    cyc(0, 4'b0000, 0, 11, 0, 1, "to_halt");
    cyc(0, 4'b0000, 1, 11, 0, 1, "to_halt_stays");
    cyc(1, 4'b0000, 0, 0, 0, 0, "to_reset");
    for (int i = 0; i < 14; i++) cyc(0, 4'b1010, 0, 0, 0, 0, "late_fetch_wait");
    cyc(0, 4'b1010, 1, 0, 0, 0, "late_fetch_ready");
    cyc(0, 4'b1010, 1, 1, 0, 0, "late_decode");
    // Test 6: reset during MEMWRITE wait, then JAL
    cyc(0, 4'b0011, 1, 0, 1, 0, "sw2_fetch");
    cyc(0, 4'b0011, 1, 1, 1, 0, "sw2_decode");
    cyc(0, 4'b0011, 1, 2, 1, 0, "sw2_memadr");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0011, 0, 5, 1, 0, "sw2_memwrite_wait");
    cyc(1, 4'b0011, 0, 0, 0, 0, "rst_in_memwrite");
    cyc(0, 4'b0101, 1, 0, 0, 0, "jal_fetch");
    cyc(0, 4'b0101, 1, 1, 0, 0, "jal_decode");
    cyc(0, 4'b0101, 1, 10, 0, 0, "jal_exec");
    cyc(0, 4'b0101, 1, 0, 0, 0, "jal_back_fetch");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the 16-bit multicycle RISC-V core. It sequences fetch, decode, execute, memory and writeback steps.
- It generates every datapath enable, and produces the 2-bit ALUOp class consumed by the ALU controller: 00 store/address ADD, 01 branch, 10 R-type, 11 I-type.
- It waits on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles a memory state may wait for mem_ready before timeout (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  4  instruction opcode field from IR. Encodings: R 0000, ADDI 0001, LW 0010, SW 0011, BR 0100, JAL 0101, HALT 1111; all others illegal.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if the branch condition holds.
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  2  writeback select: 00 ALUOut, 01 MDR, 10 PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 regA.
- ALUSrcB  out  2  ALU B select: 00 regB, 01 constant 2, 10 imm, 11 imm<<1.
- ALUOp  out  2  ALU class to the ALU controller.
- PCSource  out  2  PC next select: 00 ALU result, 01 ALUOut.
- state  out  4  current state, for debug.
- illegal_op  out  1  sticky; an illegal opcode was decoded.
- mem_err  out  1  sticky; a memory wait timed out.
- halted  out  1  FSM is in HALT.

Behaviour:
- **Reset.** While rst=1 all outputs are 0. The state, wait counter, illegal_op and mem_err registers clear at the edge. The first cycle after rst falls is FETCH (state=0).
- **Default.** Any output not listed for a state is 0.
- **Output timing.** Outputs are decoded from state (Moore). Exception: PCWrite/IRWrite in FETCH are gated by mem_ready (Mealy).
- **State encodings:** FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, HALT 11.
- **FETCH.**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- **DECODE.**
  - Outputs: ALUSrcA=00, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Dispatch:
    - R -> EXEC_R
    - ADDI -> EXEC_I
    - LW/SW -> MEMADR
    - BR -> BRANCH
    - JAL -> JAL
    - HALT -> HALT
    - illegal -> FETCH, and illegal_op is set at that edge.
- **MEMADR.**
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00.
  - LW -> MEMREAD; SW -> MEMWRITE. Opcode is stable from IR.
- **MEMREAD.** MemRead=1, IorD=1. mem_ready -> MEMWB.
- **MEMWB.** RegWrite=1, MemtoReg=01. -> FETCH.
- **MEMWRITE.** MemWrite=1, IorD=1. mem_ready -> FETCH.
- **EXEC_R.** ALUSrcA=01, ALUSrcB=00, ALUOp=10. -> ALUWB.
- **EXEC_I.** ALUSrcA=01, ALUSrcB=10, ALUOp=11. -> ALUWB.
- **ALUWB.** RegWrite=1, MemtoReg=00. -> FETCH.
- **BRANCH.** ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
- **JAL.** RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01. -> FETCH.
  - The register file samples the old PC+2 before the PC updates at the same edge.
- **HALT.** halted=1. Stays until rst.
- **Wait counter (FETCH, MEMREAD, MEMWRITE).**
  - Width is ceil(log2(MEM_WAIT_MAX+1)).
  - Clears on entry to any state and when mem_ready=1.
  - Increments each cycle a memory state waits with mem_ready=0.
  - If it reaches MEM_WAIT_MAX while mem_ready=0 -> HALT, and mem_err is set. mem_ready=1 in the same cycle wins: normal transition, no error.
- **Memory request hold.** MemRead/MemWrite stay asserted every cycle of a wait. mem_ready outside the memory states is ignored.
- **Reset mid-operation.** rst in any state, including a memory wait or HALT, returns to FETCH next cycle. No write strobe is asserted during the rst cycle.
- **Cycle counts with zero-wait memory:**
  - R/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BR: 3 cycles.
  - JAL: 3 cycles.

Test Plan:
1. **R-type, zero wait.** rst 1 cycle, opcode=0000, mem_ready=1 always -> state sequence 0,1,6,8,0. ALUOp=10 in EXEC_R. RegWrite=1 only in ALUWB. IRWrite=PCWrite=1 in FETCH.
2. **LW with 3 wait cycles.** opcode=0010, mem_ready low 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles with MemRead=IorD=1 throughout. MEMWB follows with MemtoReg=01, RegWrite=1. Total 8 cycles.
3. **SW then BR.** SW zero wait -> MemWrite=1 for exactly 1 cycle. BR -> ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH, ALUOp=00 in DECODE.
4. **Illegal opcode.** opcode=1010 -> DECODE returns to FETCH, illegal_op=1 from the next cycle and remains 1 through subsequent legal instructions until rst.
5. **Fetch timeout.** MEM_WAIT_MAX=15, mem_ready=0 from reset -> HALT after 15 cycles with mem_err=1, halted=1. A variant with mem_ready=1 on the 15th cycle -> DECODE, mem_err=0.
6. **Reset during MEMWRITE wait.** rst=1 -> all outputs 0 that cycle, state=0 next cycle, illegal_op/mem_err cleared. JAL afterwards -> RegWrite=PCWrite=1, MemtoReg=10 in a single cycle.
